gestor_int_vect: RTL and testbench
==================================

# gestor_int_vect

Parametrised vectored interrupt controller for the single-cycle CPU datapath; it supersedes the fixed 4-port interrupt manager. It edge-detects `NCH` request lines, latches them as pending, applies a per-channel mask and a global enable, and selects the highest-priority channel. It then pulses `int_to_uc` with a per-channel vector address that the datapath muxes into the PC while pushing the return address. It tracks in-service channels until the control unit signals end-of-interrupt, with optional priority nesting.

## Interface
Parameters:
- `NCH`, 4: number of interrupt channels, 1..16; channel 0 has the highest priority.
- `PCW`, 10: PC / vector width.
- `VBASE`, 10'h300: vector address of channel 0.
- `VSTRIDE`, 16: vector spacing between consecutive channels.
- `CW` (localparam): $clog2(NCH), minimum 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  NCH  request lines, synchronous to `clk`; rising edge = event.
- `mask_we`  in  1  write enable for the mask register.
- `mask_d`  in  NCH  new mask; bit=1 enables the channel.
- `gie_we`  in  1  write enable for the global enable.
- `gie_d`  in  1  new global enable value.
- `fin_int`  in  1  end-of-interrupt from the control unit (one-cycle pulse).
- `int_to_uc`  out  1  dispatch pulse to the control unit and PC/stack muxes.
- `vector`  out  PCW  handler address of the last dispatched channel.
- `cur_ch`  out  CW  index of the last dispatched channel.
- `pending`  out  NCH  pending register.
- `in_service`  out  NCH  in-service register.

## Operation
- Edge detect: `irq_q` holds the previous `irq`. An event on channel i is `irq[i] & ~irq_q[i]`, and it sets `pending[i]`. A held-high line produces one event only.
- Pending depth is one per channel. An event on a channel that is already pending is absorbed.
- Eligible set: `pending & mask`, and all-zero when `gie`=0.
- Winner: the lowest-index eligible bit.
- Dispatch condition: winner exists, `int_to_uc`=0, `fin_int`=0, and the in-service rule holds:
  - Without nesting: `in_service` must be all-zero.
  - With nesting: the winner index must be lower than the lowest set bit of `in_service`, or `in_service` must be all-zero.
- On dispatch, at the next clock edge:
  - `int_to_uc`<=1 for exactly one cycle.
  - `cur_ch`<=winner.
  - `vector`<=(VBASE + winner*VSTRIDE) mod 2^PCW.
  - `pending[winner]`<=0 and `in_service[winner]`<=1.
- If an event on the winner arrives in the same cycle as its dispatch, the pending set wins and `pending[winner]` stays 1.
- `fin_int` clears the lowest set bit of `in_service`. With `in_service`=0 it has no effect.
- `mask_we` / `gie_we` take effect from the next cycle and never clear `pending`. Events on masked channels still latch into `pending`.
- Reset (any time, including mid-dispatch):
  - `pending`=0, `in_service`=0, `irq_q`=0.
  - `mask`=all ones, `gie`=1.
  - `int_to_uc`=0, `vector`=0, `cur_ch`=0.
  - Outputs are stable from reset assertion.

## Timing
- Event on `irq` visible at edge k sets `pending` at edge k.
- Earliest `int_to_uc` is after edge k+1, so it is high during cycle k+1. `vector` and `cur_ch` are valid in the same cycle and hold until the next dispatch.
- Two `int_to_uc` pulses are always separated by at least one low cycle.
- After `fin_int` at edge j, the earliest next dispatch is after edge j+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `GESTOR_INT_NEST_EN` defined: nesting rule active. A higher-priority eligible channel preempts a lower in-service one, and `in_service` may hold multiple bits.
- `GESTOR_INT_NEST_EN` undefined: at most one bit of `in_service` is set. All new dispatches wait for `fin_int`.

## Test plan
- Reset, then `irq`=4'b0100 rising at edge 5 → `pending`=4'b0100 after edge 5. During cycle 6: `int_to_uc`=1, `vector`=10'h320, `cur_ch`=2, `in_service`=4'b0100. During cycle 7: `int_to_uc`=0.
- `irq[3]` and `irq[1]` rise in the same cycle → dispatch ch1 (`vector`=10'h310); ch3 stays pending. `fin_int` → ch3 dispatched (`vector`=10'h330) two cycles later.
- `mask_d`=4'b1110 written, `irq[0]` rises → `pending[0]`=1 and no `int_to_uc`. Then write `mask_d`=4'b1111 → ch0 dispatched next cycle with `vector`=10'h300.
- ch2 in service, `irq[0]` rises:
  - With `GESTOR_INT_NEST_EN`: ch0 dispatched, `in_service`=4'b0101. First `fin_int` gives 4'b0100, second gives 4'b0000.
  - Without the macro: ch0 waits until after `fin_int`.
- `irq[1]` held high for 20 cycles → exactly one dispatch. `reset` low during an `int_to_uc` cycle → `int_to_uc`, `pending`, `in_service` drop to 0 immediately.
- `VBASE`=10'h3F8, `VSTRIDE`=8, ch3 dispatched → `vector`=10'h010 (wrap-around).

Source files
------------

// File: rtl/gestor_int_vect_if.sv
// Bus between the vectored interrupt controller and the CPU control unit / PC muxes.
// The slave modport is the controller side; the master modport is the CPU side.
interface gestor_int_vect_if #(
  parameter int NCH = 4,
  parameter int PCW = 10
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] irq;
  logic           mask_we;
  logic [NCH-1:0] mask_d;
  logic           gie_we;
  logic           gie_d;
  logic           fin_int;
  logic           int_to_uc;
  logic [PCW-1:0] vector;
  logic [CW-1:0]  cur_ch;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] in_service;

  modport master (
    output irq, mask_we, mask_d, gie_we, gie_d, fin_int,
    input  int_to_uc, vector, cur_ch, pending, in_service
  );

  modport slave (
    input  irq, mask_we, mask_d, gie_we, gie_d, fin_int,
    output int_to_uc, vector, cur_ch, pending, in_service
  );
endinterface

// File: rtl/gestor_int_vect.sv
// Vectored interrupt controller: edge-detected pending latches, mask/global enable,
// fixed priority (channel 0 highest). Define GESTOR_INT_NEST_EN to allow priority nesting.
module gestor_int_vect #(
  parameter int             NCH     = 4,
  parameter int             PCW     = 10,
  parameter logic [PCW-1:0] VBASE   = 10'h300,
  parameter int             VSTRIDE = 16
) (
  input logic              clk,
  input logic              reset,
  gestor_int_vect_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] irq_q, pend_q, isr_q, mask_q;
  logic           gie_q, int_q;
  logic [PCW-1:0] vec_q;
  logic [CW-1:0]  ch_q;

  logic [NCH-1:0] events, elig, win_oh, pend_d, isr_d;
  logic [CW-1:0]  win, isr_low;
  logic           win_any, isr_any, isr_ok, dispatch;

  // Handler address wraps modulo 2^PCW.
  function automatic logic [PCW-1:0] vec_of(input logic [CW-1:0] ch);
    logic [31:0] sum;
    sum = 32'(VBASE) + 32'(ch) * 32'(VSTRIDE);
    return sum[PCW-1:0];
  endfunction

  always_comb begin
    events  = bus.irq & ~irq_q;
    elig    = gie_q ? (pend_q & mask_q) : '0;
    win     = '0;
    win_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win     = CW'(i);
        win_any = 1'b1;
      end
    end
    isr_low = '0;
    isr_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (isr_q[i]) begin
        isr_low = CW'(i);
        isr_any = 1'b1;
      end
    end
`ifdef GESTOR_INT_NEST_EN
    isr_ok = !isr_any || (win < isr_low);
`else
    isr_ok = !isr_any;
`endif
    dispatch = win_any && !int_q && !bus.fin_int && isr_ok;
    win_oh   = dispatch ? (NCH'(1) << win) : '0;
    // A same-cycle event on the winner re-arms its pending bit.
    pend_d   = (pend_q & ~win_oh) | events;
    isr_d    = bus.fin_int ? (isr_q & (isr_q - NCH'(1))) : isr_q;
    isr_d    = isr_d | win_oh;
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      mask_q <= '1;
      gie_q  <= 1'b1;
      int_q  <= 1'b0;
      vec_q  <= '0;
      ch_q   <= '0;
    end else begin
      irq_q  <= bus.irq;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      int_q  <= dispatch;
      if (dispatch) begin
        ch_q  <= win;
        vec_q <= vec_of(win);
      end
      if (bus.mask_we) mask_q <= bus.mask_d;
      if (bus.gie_we)  gie_q  <= bus.gie_d;
    end
  end

  assign bus.int_to_uc  = int_q;
  assign bus.vector     = vec_q;
  assign bus.cur_ch     = ch_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = isr_q;
endmodule

// File: tb/tb_gestor_int_vect.sv
// Directed plus randomized bench for gestor_int_vect against a behavioural model;
// a second instance with VBASE=10'h3F8, VSTRIDE=8 exercises vector wrap-around.
module tb_gestor_int_vect;
  localparam int NCH = 4;
  localparam int PCW = 10;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0] irq;
  logic mask_we, gie_we, gie_d, fin_int;
  logic [NCH-1:0] mask_d;

  always #5 clk = ~clk;

  gestor_int_vect_if #(.NCH(NCH), .PCW(PCW)) bus_a ();
  gestor_int_vect_if #(.NCH(NCH), .PCW(PCW)) bus_b ();

  assign bus_a.irq = irq;     assign bus_b.irq = irq;
  assign bus_a.mask_we = mask_we; assign bus_b.mask_we = mask_we;
  assign bus_a.mask_d = mask_d;   assign bus_b.mask_d = mask_d;
  assign bus_a.gie_we = gie_we;   assign bus_b.gie_we = gie_we;
  assign bus_a.gie_d = gie_d;     assign bus_b.gie_d = gie_d;
  assign bus_a.fin_int = fin_int; assign bus_b.fin_int = fin_int;

  gestor_int_vect #(.NCH(NCH), .PCW(PCW), .VBASE(10'h300), .VSTRIDE(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  gestor_int_vect #(.NCH(NCH), .PCW(PCW), .VBASE(10'h3F8), .VSTRIDE(8)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Behavioural model: in-service kept as a set of channel numbers
  bit m_pend[NCH];
  bit m_mask[NCH];
  bit m_prev[NCH];
  bit m_gie;
  int m_isq[$];
  bit m_int;
  int m_ch, m_vec_a, m_vec_b;

  int total = 0;
  int bad = 0;

  function automatic int vec_for(int base, int stride, int ch);
    return (base + ch * stride) % (1 << PCW);
  endfunction

  function automatic int isq_min();
    int mn = NCH;
    foreach (m_isq[k]) if (m_isq[k] < mn) mn = m_isq[k];
    return mn;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [31:0] isr_vec();
    logic [31:0] v = '0;
    foreach (m_isq[k]) v[m_isq[k]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
    end
    m_gie = 1; m_isq.delete(); m_int = 0; m_ch = 0; m_vec_a = 0; m_vec_b = 0;
  endtask

  task automatic model_edge();
    int w;
    bit ok, d;
    bit ev[NCH];
    for (int i = 0; i < NCH; i++) ev[i] = irq[i] && !m_prev[i];
    w = -1;
    if (m_gie)
      for (int i = 0; i < NCH; i++)
        if (w < 0 && m_pend[i] && m_mask[i]) w = i;
`ifdef GESTOR_INT_NEST_EN
    ok = (m_isq.size() == 0) || (w < isq_min());
`else
    ok = (m_isq.size() == 0);
`endif
    d = (w >= 0) && !m_int && !fin_int && ok;
    if (fin_int && m_isq.size() > 0) begin
      int mn = isq_min();
      foreach (m_isq[k]) if (m_isq[k] == mn) begin m_isq.delete(k); break; end
    end
    if (d) begin
      m_pend[w] = 0;
      m_isq.push_back(w);
      m_ch = w;
      m_vec_a = vec_for(10'h300, 16, w);
      m_vec_b = vec_for(10'h3F8, 8, w);
    end
    for (int i = 0; i < NCH; i++) begin
      if (ev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
      if (mask_we) m_mask[i] = mask_d[i];
    end
    if (gie_we) m_gie = gie_d;
    m_int = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("int_a", bus_a.int_to_uc, m_int);
    check("int_b", bus_b.int_to_uc, m_int);
    check("vec_a", bus_a.vector, m_vec_a);
    check("vec_b", bus_b.vector, m_vec_b);
    check("ch_a", bus_a.cur_ch, m_ch);
    check("pend_a", bus_a.pending, pend_vec());
    check("isr_a", bus_a.in_service, isr_vec());
    check("isr_b", bus_b.in_service, isr_vec());
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    fin_int = 0; mask_we = 0; gie_we = 0;
  endtask

  int pulses;

  initial begin
    reset = 0; irq = '0; mask_we = 0; mask_d = '0; gie_we = 0; gie_d = 0; fin_int = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    reset = 1;

    // Single request on channel 2
    irq = 4'b0100;
    cycle(); check("p1_pend", bus_a.pending, 4'b0100);
    cycle(); check("p1_int", bus_a.int_to_uc, 1'b1); check("p1_vec", bus_a.vector, 10'h320);
    check("p1_ch", bus_a.cur_ch, 2); check("p1_isr", bus_a.in_service, 4'b0100);
    cycle(); check("p1_int_low", bus_a.int_to_uc, 1'b0);
    irq = '0; fin_int = 1; cycle(); cycle();

    // Simultaneous channels 3 and 1
    irq = 4'b1010;
    cycle(); cycle(); check("p2_vec1", bus_a.vector, 10'h310); check("p2_pend3", bus_a.pending, 4'b1000);
    cycle(); cycle();
    fin_int = 1; cycle(); check("p2_gap", bus_a.int_to_uc, 1'b0);
    cycle(); check("p2_int3", bus_a.int_to_uc, 1'b1); check("p2_vec3", bus_a.vector, 10'h330);
    irq = '0; fin_int = 1; cycle(); cycle();

    // Masked channel latches but does not dispatch
    mask_we = 1; mask_d = 4'b1110; cycle();
    irq = 4'b0001; cycle(); cycle(); cycle();
    check("p3_pend", bus_a.pending, 4'b0001); check("p3_noint", bus_a.int_to_uc, 1'b0);
    mask_we = 1; mask_d = 4'b1111; cycle();
    cycle(); check("p3_int", bus_a.int_to_uc, 1'b1); check("p3_vec", bus_a.vector, 10'h300);
    irq = '0; fin_int = 1; cycle(); cycle();

    // Higher priority arrives while channel 2 is in service
    irq = 4'b0100; cycle(); cycle();
    irq = 4'b0101; cycle(); cycle();
`ifdef GESTOR_INT_NEST_EN
    check("p4_nest_isr", bus_a.in_service, 4'b0101); check("p4_nest_ch", bus_a.cur_ch, 0);
    cycle(); fin_int = 1; cycle(); check("p4_fin1", bus_a.in_service, 4'b0100);
    fin_int = 1; cycle(); check("p4_fin2", bus_a.in_service, 4'b0000);
`else
    check("p4_wait_int", bus_a.int_to_uc, 1'b0); check("p4_wait_isr", bus_a.in_service, 4'b0100);
    fin_int = 1; cycle(); cycle();
    check("p4_late_int", bus_a.int_to_uc, 1'b1); check("p4_late_ch", bus_a.cur_ch, 0);
    cycle(); fin_int = 1; cycle(); check("p4_fin", bus_a.in_service, 4'b0000);
`endif
    irq = '0; cycle();

    // Held-high line gives a single dispatch
    irq = 4'b0010; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (bus_a.int_to_uc) pulses++;
    end
    check("p5_one_pulse", pulses, 1);
    irq = '0; fin_int = 1; cycle(); cycle();

    // Global enable gating
    gie_we = 1; gie_d = 0; cycle();
    irq = 4'b0001; cycle(); cycle(); cycle();
    check("gie_off", bus_a.int_to_uc, 1'b0);
    gie_we = 1; gie_d = 1; cycle(); cycle();
    check("gie_on", bus_a.int_to_uc, 1'b1);
    irq = '0; fin_int = 1; cycle(); cycle();

    // Wrap-around vector, then reset asserted during the dispatch cycle
    irq = 4'b1000; cycle(); cycle();
    check("wrap_int", bus_b.int_to_uc, 1'b1); check("wrap_vec", bus_b.vector, 10'h010);
    #2; reset = 0; irq = '0;
    #1; model_reset();
    check("rst_int", bus_a.int_to_uc, 1'b0); check("rst_pend", bus_a.pending, 4'b0000);
    check("rst_isr", bus_a.in_service, 4'b0000); check("rst_vec", bus_a.vector, 10'h000);
    @(posedge clk); #1; reset = 1;
    cycle();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) irq = NCH'($urandom_range(0, 15));
      fin_int = ($urandom_range(0, 5) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d = NCH'($urandom_range(0, 15));
      gie_we = ($urandom_range(0, 31) == 0);
      gie_d = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
